// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory patch controller.
// The key-buffering variant of the controller is selected with KEY_FIFO_EN.
package imem_pkg;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned FLAG_WORD = 17;
  localparam int unsigned CODE_WORD = 19;
  localparam logic [31:0] ACK_PC    = 32'h0000_0050;
  localparam logic [31:0] FLAG_BASE = 32'hE359_0000;
  localparam logic [31:0] CODE_BASE = 32'hE3A0_2000;

  typedef enum logic [2:0] {
    INIT_CLR = 3'd0,
    IDLE     = 3'd1,
    WR_CODE  = 3'd2,
    WR_FLAG  = 3'd3,
    WAIT_ACK = 3'd4,
    CLR_FLAG = 3'd5
  } patch_state_t;

endpackage

// File: rtl/imem_patch_ctrl_key_fifo.sv
// Small synchronous key FIFO with asynchronous reset; used when KEY_FIFO_EN is defined.
module key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 5
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leave the occupancy unchanged.
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/imem_patch_ctrl.sv
// Sequences keyboard-driven patching of the polled CMP r9 flag and MOV r2 code words.
// Define KEY_FIFO_EN to place a 4-entry key FIFO in front of the FSM.
module imem_patch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = imem_pkg::ADDR_W,
  parameter int unsigned FLAG_WORD = imem_pkg::FLAG_WORD,
  parameter int unsigned CODE_WORD = imem_pkg::CODE_WORD,
  parameter logic [31:0] ACK_PC    = imem_pkg::ACK_PC,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [31:0] FLAG_BASE = imem_pkg::FLAG_BASE,
  parameter logic [31:0] CODE_BASE = imem_pkg::CODE_BASE
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [4:0]        key_code,
  output logic              key_ready,
  input  logic [31:0]       pc,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              ack_pulse,
  output logic              drop_pulse,
  output patch_state_t      dbg_state
);

  // Handshake: a key transfers on a rising CLK edge where key_valid && key_ready.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  patch_state_t      state_q, state_d;
  logic [4:0]        code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_d, ack_d, drop_d, busy_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [31:0]       wdata_d;
  logic              accept;
  logic              key_avail;
  logic [4:0]        key_in;

`ifdef KEY_FIFO_EN
  logic fifo_full, fifo_empty;
  logic [4:0] fifo_dout;

  key_fifo #(.DEPTH(4), .W(5)) u_key_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (key_valid && key_ready),
    .din   (key_code),
    .pop   (accept),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign key_ready = !fifo_full;
  assign key_avail = !fifo_empty;
  assign key_in    = fifo_dout;
`else
  assign key_avail = key_valid && key_ready;
  assign key_in    = key_code;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) key_ready <= 1'b0;
    else       key_ready <= (state_d == IDLE);
  end
`endif

  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    ack_d   = 1'b0;
    drop_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      INIT_CLR: begin
        we_d    = 1'b1;
        waddr_d = ADDR_W'(FLAG_WORD);
        wdata_d = FLAG_BASE;
        state_d = IDLE;
      end
      IDLE: begin
        if (key_avail) begin
          accept  = 1'b1;
          code_d  = key_in;
          state_d = WR_CODE;
        end
      end
      WR_CODE: begin
        we_d    = 1'b1;
        waddr_d = ADDR_W'(CODE_WORD);
        wdata_d = CODE_BASE | {27'b0, code_q};
        state_d = WR_FLAG;
      end
      WR_FLAG: begin
        we_d    = 1'b1;
        waddr_d = ADDR_W'(FLAG_WORD);
        wdata_d = FLAG_BASE | 32'd1;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // The fetch check comes first so an ack on the last counted cycle still wins.
        if (pc == ACK_PC) begin
          ack_d   = 1'b1;
          state_d = CLR_FLAG;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          drop_d  = 1'b1;
          state_d = CLR_FLAG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLR_FLAG: begin
        we_d    = 1'b1;
        waddr_d = ADDR_W'(FLAG_WORD);
        wdata_d = FLAG_BASE;
        state_d = IDLE;
      end
      default: state_d = INIT_CLR;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= INIT_CLR;
      code_q     <= '0;
      cnt_q      <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      ack_pulse  <= 1'b0;
      drop_pulse <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      mem_we     <= we_d;
      mem_waddr  <= waddr_d;
      mem_wdata  <= wdata_d;
      ack_pulse  <= ack_d;
      drop_pulse <= drop_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_imem_patch_ctrl.sv
// Scoreboard bench for imem_patch_ctrl: expected writes and pulses are queued by the
// stimulus tasks and popped by a negedge monitor whenever the DUT presents them.
module tb_imem_patch_ctrl;

  localparam int          TO      = 8;
  localparam logic [31:0] ACK     = 32'h0000_0050;
  localparam logic [31:0] F_BASE  = 32'hE359_0000;
  localparam logic [31:0] C_BASE  = 32'hE3A0_2000;
  localparam logic [8:0]  F_WORD  = 9'd17;
  localparam logic [8:0]  C_WORD  = 9'd19;
  localparam logic [1:0]  P_ACK   = 2'b01;
  localparam logic [1:0]  P_DROP  = 2'b10;
`ifdef KEY_FIFO_EN
  localparam int   LAT     = 1;
  localparam logic RST_RDY = 1'b1;
`else
  localparam int   LAT     = 0;
  localparam logic RST_RDY = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;
  logic [31:0] pc;
  logic        mem_we;
  logic [8:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        ack_pulse;
  logic        drop_pulse;
  imem_pkg::patch_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [40:0] exp_q[$];
  logic [1:0]  pulse_q[$];

  imem_patch_ctrl #(.TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .pc         (pc),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .ack_pulse  (ack_pulse),
    .drop_pulse (drop_pulse),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (mem_we) begin
      if (exp_q.size() == 0) check("unexpected_write", {23'b0, mem_waddr, mem_wdata}, 64'h0);
      else check("write", {23'b0, mem_waddr, mem_wdata}, {23'b0, exp_q.pop_front()});
    end
    if (ack_pulse || drop_pulse) begin
      if (pulse_q.size() == 0) check("unexpected_pulse", {62'b0, drop_pulse, ack_pulse}, 64'h0);
      else check("pulse", {62'b0, drop_pulse, ack_pulse}, {62'b0, pulse_q.pop_front()});
    end
  end

  // Driver tasks
  task automatic expect_key(input logic [4:0] c);
    exp_q.push_back({C_WORD, C_BASE | {27'b0, c}});
    exp_q.push_back({F_WORD, F_BASE | 32'd1});
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge CLK);
    while (!key_ready && guard < 100) begin
      guard++;
      @(negedge CLK);
    end
    if (!key_ready) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge CLK);
    while (busy && guard < 100) begin
      guard++;
      @(negedge CLK);
    end
    check("idle_reached", {63'b0, busy}, 64'd0);
    check("ready_in_idle", {63'b0, key_ready}, 64'd1);
  endtask

  // delay: WAIT_ACK cycles before pc shows ACK (-1 = never); hold: pc=ACK from the offer on.
  task automatic do_key(input logic [4:0] c, input int delay, input bit hold);
    expect_key(c);
    exp_q.push_back({F_WORD, F_BASE});
    pulse_q.push_back((hold || (delay >= 0 && delay < TO)) ? P_ACK : P_DROP);
    wait_ready();
    if (hold) pc = ACK;
    key_valid = 1'b1;
    key_code  = c;
    @(posedge CLK); #1;
    key_valid = 1'b0;
    repeat (2 + LAT) @(posedge CLK);
    #1;
    if (hold) begin
      @(posedge CLK); #1;
      pc = 32'h0;
    end else if (delay >= 0) begin
      repeat (delay) @(posedge CLK);
      #1 pc = ACK;
      @(posedge CLK); #1;
      pc = 32'h0;
    end
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    {63'b0, mem_we}, 64'd0);
    check({tag, "_waddr"}, {55'b0, mem_waddr}, 64'd0);
    check({tag, "_wdata"}, {32'b0, mem_wdata}, 64'd0);
    check({tag, "_busy"},  {63'b0, busy}, 64'd1);
    check({tag, "_ready"}, {63'b0, key_ready}, {63'b0, RST_RDY});
    check({tag, "_pulses"}, {62'b0, drop_pulse, ack_pulse}, 64'd0);
    check({tag, "_state"}, {61'b0, dbg_state}, {61'b0, imem_pkg::INIT_CLR});
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 5'd0;
    pc        = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");

    // Init clear write, then idle.
    exp_q.push_back({F_WORD, F_BASE});
    @(negedge CLK) reset = 1'b0;
    @(posedge CLK); #1;
    check("init_we", {63'b0, mem_we}, 64'd1);
    @(posedge CLK); #1;
    check("init_idle_we", {63'b0, mem_we}, 64'd0);
    check("init_idle_ready", {63'b0, key_ready}, 64'd1);
    check("init_idle_busy", {63'b0, busy}, 64'd0);

    // Ack on the first WAIT_ACK cycle.
    do_key(5'h1E, 0, 1'b0);
    // Ack a few cycles in.
    do_key(5'h03, 3, 1'b0);
    // pc never reaches ACK: timeout drop.
    do_key(5'h05, -1, 1'b0);
    // pc=ACK held through WR_CODE/WR_FLAG: acked only once WAIT_ACK is reached.
    do_key(5'h11, 0, 1'b1);
    // Ack on the same cycle as the timeout: ack wins.
    do_key(5'h1F, TO - 1, 1'b0);
    // Key code 0 boundary.
    do_key(5'h00, 1, 1'b0);

    // Asynchronous reset while waiting for the ack.
    expect_key(5'h0A);
    wait_ready();
    key_valid = 1'b1;
    key_code  = 5'h0A;
    @(posedge CLK); #1;
    key_valid = 1'b0;
    repeat (3 + LAT) @(posedge CLK);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.push_back({F_WORD, F_BASE});
    @(negedge CLK) reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("post_reset_idle", {63'b0, busy}, 64'd0);

`ifdef KEY_FIFO_EN
    begin
      bit saw_full = 1'b0;
      int guard;
      pc = ACK;
      for (int k = 1; k <= 5; k++) begin
        expect_key(5'(k));
        exp_q.push_back({F_WORD, F_BASE});
        pulse_q.push_back(P_ACK);
      end
      for (int k = 1; k <= 5; k++) begin
        guard = 0;
        @(negedge CLK);
        while (!key_ready && guard < 100) begin
          saw_full = 1'b1;
          guard++;
          @(negedge CLK);
        end
        key_valid = 1'b1;
        key_code  = 5'(k);
        @(posedge CLK); #1;
        key_valid = 1'b0;
      end
      check("fifo_saw_full", {63'b0, saw_full}, 64'd1);
      guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 200) begin
        guard++;
        @(negedge CLK);
      end
      pc = 32'h0;
    end
`endif

    repeat (5) @(negedge CLK);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    check("pulses_drained", 64'(pulse_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
